// File: rtl/per2axi_resp_merge.sv
// ----------------------------------------------------------------------------
// per2axi_resp_merge
//
// Purpose:
//   Merges AXI write responses (B) and read responses (R) onto the single
//   peripheral response port of the per2axi bridge. The peripheral port
//   cannot apply backpressure, so at most one response is issued per cycle.
//   B and R are arbitrated with a one-bit alternating priority flag.
//   Read data arrives 64 bits wide. The correct 32-bit lane is chosen from a
//   small lane FIFO that the request side fills with address bit 2 each time
//   it issues a read.
//
// Optional feature:
//   `define PER2AXI_RESP_ERR_CNT_EN enables a saturating 16-bit counter of
//   granted error responses on err_cnt_o. When the macro is undefined,
//   err_cnt_o is tied to zero and no counter register exists.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   b_*_i / b_ready_o B channel from the B buffer (valid/resp/id/user, accept)
//   r_*_i / r_ready_o R channel from the R buffer (valid/data/resp/last/id/
//                     user, accept)
//   lane_push_i       request side issued a read; lane_sel_i = its addr[2]
//   lane_ready_o      lane FIFO has room
//   per_r_*_o         registered peripheral response (valid pulse, opc, id,
//                     rdata)
//   err_cnt_o         error response count (optional feature)
// ----------------------------------------------------------------------------
module per2axi_resp_merge #(
    parameter int ID_WIDTH        = 4,
    parameter int USER_WIDTH      = 6,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int PER_DATA_WIDTH  = 32,
    parameter int LANE_FIFO_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      b_valid_i,
    input  logic [1:0]                b_resp_i,
    input  logic [ID_WIDTH-1:0]       b_id_i,
    input  logic [USER_WIDTH-1:0]     b_user_i,
    output logic                      b_ready_o,

    input  logic                      r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    input  logic [ID_WIDTH-1:0]       r_id_i,
    input  logic [USER_WIDTH-1:0]     r_user_i,
    output logic                      r_ready_o,

    input  logic                      lane_push_i,
    input  logic                      lane_sel_i,
    output logic                      lane_ready_o,

    output logic                      per_r_valid_o,
    output logic                      per_r_opc_o,
    output logic [ID_WIDTH-1:0]       per_r_id_o,
    output logic [PER_DATA_WIDTH-1:0] per_r_rdata_o,

    output logic [15:0]               err_cnt_o
);

    localparam int PTR_W = (LANE_FIFO_DEPTH > 1) ? $clog2(LANE_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LANE_FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Lane FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [LANE_FIFO_DEPTH-1:0] lane_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    logic fifo_empty;
    logic lane_push_acc;
    logic lane_pop;
    logic head_sel;

    // Arbitration state and results
    logic prio_b;
    logic b_eligible;
    logic r_eligible;
    logic grant_b;
    logic grant_r;

    // RUSER, RLAST and the low resp bits carry no information we act on.
    logic unused_inputs;
    assign unused_inputs = ^{b_resp_i[0], r_resp_i[0], r_last_i, b_user_i, r_user_i};

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never opens room for a push while the FIFO is full.
    assign fifo_empty    = (count == '0);
    assign lane_ready_o  = (count != FULL_CNT);
    assign lane_push_acc = lane_push_i && lane_ready_o;
    assign lane_pop      = grant_r;
    assign head_sel      = lane_mem[rd_ptr];

    // ------------------------------------------------------------------
    // Arbitration: an R beat is only eligible if its lane select is known.
    // When both channels compete, prio_b picks the winner (0 = R, 1 = B).
    // ------------------------------------------------------------------
    always_comb begin
        b_eligible = b_valid_i;
        r_eligible = r_valid_i && !fifo_empty;
        grant_b    = 1'b0;
        grant_r    = 1'b0;
        if (b_eligible && r_eligible) begin
            grant_b = prio_b;
            grant_r = !prio_b;
        end else begin
            grant_b = b_eligible;
            grant_r = r_eligible;
        end
    end

    assign b_ready_o = grant_b;
    assign r_ready_o = grant_r;

    // After any grant the flag points at the channel that did not win, so
    // sustained contention alternates R, B, R, B.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_b <= 1'b0;
        end else if (grant_r) begin
            prio_b <= 1'b1;
        end else if (grant_b) begin
            prio_b <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Lane FIFO pointers and occupancy. Pointers wrap naturally because
    // the depth is a power of two.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (lane_push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (lane_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({lane_push_acc, lane_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Lane storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk_i) begin
        if (lane_push_acc) begin
            lane_mem[wr_ptr] <= lane_sel_i;
        end
    end

    // ------------------------------------------------------------------
    // Output register. Valid pulses for one cycle per grant; id, opc and
    // rdata hold their last values when nothing is granted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            per_r_valid_o <= 1'b0;
            per_r_opc_o   <= 1'b0;
            per_r_id_o    <= '0;
            per_r_rdata_o <= '0;
        end else begin
            per_r_valid_o <= grant_b || grant_r;
            if (grant_r) begin
                per_r_id_o  <= r_id_i;
                per_r_opc_o <= r_resp_i[1];
                if (head_sel) begin
                    per_r_rdata_o <= r_data_i[AXI_DATA_WIDTH-1:PER_DATA_WIDTH];
                end else begin
                    per_r_rdata_o <= r_data_i[PER_DATA_WIDTH-1:0];
                end
            end else if (grant_b) begin
                per_r_id_o    <= b_id_i;
                per_r_opc_o   <= b_resp_i[1];
                per_r_rdata_o <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional error response counter (SLVERR/DECERR both have resp[1]=1).
    // ------------------------------------------------------------------
`ifdef PER2AXI_RESP_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic        err_event;

    assign err_event = (grant_b && b_resp_i[1]) || (grant_r && r_resp_i[1]);

    // Saturates rather than wrapping so a long error burst stays visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= 16'h0000;
        end else if (err_event && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_per2axi_resp_merge.sv
// ----------------------------------------------------------------------------
// tb_per2axi_resp_merge
//
// Directed testbench for per2axi_resp_merge. Inputs change 1 time unit after
// each rising edge. Combinational accepts are sampled in the same cycle, and
// registered outputs are sampled 1 time unit after the following edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_per2axi_resp_merge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        b_valid_i;
    logic [1:0]  b_resp_i;
    logic [3:0]  b_id_i;
    logic [5:0]  b_user_i;
    logic        b_ready_o;
    logic        r_valid_i;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_last_i;
    logic [3:0]  r_id_i;
    logic [5:0]  r_user_i;
    logic        r_ready_o;
    logic        lane_push_i;
    logic        lane_sel_i;
    logic        lane_ready_o;
    logic        per_r_valid_o;
    logic        per_r_opc_o;
    logic [3:0]  per_r_id_o;
    logic [31:0] per_r_rdata_o;
    logic [15:0] err_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_err;

    per2axi_resp_merge dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .b_valid_i     (b_valid_i),
        .b_resp_i      (b_resp_i),
        .b_id_i        (b_id_i),
        .b_user_i      (b_user_i),
        .b_ready_o     (b_ready_o),
        .r_valid_i     (r_valid_i),
        .r_data_i      (r_data_i),
        .r_resp_i      (r_resp_i),
        .r_last_i      (r_last_i),
        .r_id_i        (r_id_i),
        .r_user_i      (r_user_i),
        .r_ready_o     (r_ready_o),
        .lane_push_i   (lane_push_i),
        .lane_sel_i    (lane_sel_i),
        .lane_ready_o  (lane_ready_o),
        .per_r_valid_o (per_r_valid_o),
        .per_r_opc_o   (per_r_opc_o),
        .per_r_id_o    (per_r_id_o),
        .per_r_rdata_o (per_r_rdata_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drive every stimulus input in one call.
    task automatic applyStimulus(input logic bv, input logic [1:0] bresp, input logic [3:0] bid,
                                 input logic rv, input logic [63:0] rdata, input logic [1:0] rresp,
                                 input logic [3:0] rid, input logic push, input logic sel);
        b_valid_i   = bv;
        b_resp_i    = bresp;
        b_id_i      = bid;
        r_valid_i   = rv;
        r_data_i    = rdata;
        r_resp_i    = rresp;
        r_id_i      = rid;
        lane_push_i = push;
        lane_sel_i  = sel;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkResp(input string tag, input logic v, input logic opc,
                             input logic [3:0] id, input logic [31:0] rdata);
        checkOutput({tag, "_valid"}, 64'(per_r_valid_o), 64'(v));
        checkOutput({tag, "_opc"},   64'(per_r_opc_o),   64'(opc));
        checkOutput({tag, "_id"},    64'(per_r_id_o),    64'(id));
        checkOutput({tag, "_rdata"}, 64'(per_r_rdata_o), 64'(rdata));
    endtask

    initial begin
        b_user_i = 6'h2A;
        r_user_i = 6'h15;
        r_last_i = 1'b1;
        rst_i    = 1'b1;
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        step();
        step();
        rst_i = 1'b0;
        #1;

        // Reset state
        $display("[TB] reset state");
        checkResp("rst", 0, 0, 4'h0, 32'h0);
        checkOutput("rst_lane_ready", 64'(lane_ready_o), 64'd1);
        checkOutput("rst_b_ready", 64'(b_ready_o), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt_o), 64'd0);

        // Single write response with SLVERR
        $display("[TB] single write");
        applyStimulus(1, 2'b10, 4'h3, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        checkOutput("wr_b_ready", 64'(b_ready_o), 64'd1);
        checkOutput("wr_r_ready", 64'(r_ready_o), 64'd0);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        checkResp("wr", 1, 1, 4'h3, 32'h0);
        step();
        checkResp("wr_hold", 0, 1, 4'h3, 32'h0);

        // Lane select: high word first, then low word
        $display("[TB] lane select");
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 0);
        step();
        applyStimulus(0, 2'b00, 4'h0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 4'h1, 0, 0);
        checkOutput("lane_r_ready1", 64'(r_ready_o), 64'd1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 4'h2, 0, 0);
        checkResp("lane1", 1, 0, 4'h1, 32'hAAAA_BBBB);
        checkOutput("lane_r_ready2", 64'(r_ready_o), 64'd1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 4'h2, 0, 0);
        checkResp("lane2", 1, 0, 4'h2, 32'hCCCC_DDDD);

        // R stalls on empty lane FIFO while B is still served
        $display("[TB] stall");
        checkOutput("stall_r_ready", 64'(r_ready_o), 64'd0);
        step();
        checkOutput("stall_valid", 64'(per_r_valid_o), 64'd0);
        applyStimulus(1, 2'b00, 4'h5, 1, 64'h0123_4567_89AB_CDEF, 2'b00, 4'h7, 0, 0);
        checkOutput("stall_b_ready", 64'(b_ready_o), 64'd1);
        checkOutput("stall_r_ready2", 64'(r_ready_o), 64'd0);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        checkResp("stall_b", 1, 0, 4'h5, 32'h0);

        // Reset mid-traffic discards queued lanes and clears state
        $display("[TB] mid reset");
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 0);
        step();
        rst_i = 1'b1;
        applyStimulus(1, 2'b11, 4'hE, 1, 64'hFFFF_0000_FFFF_0000, 2'b00, 4'hD, 0, 0);
        step();
        step();
        rst_i = 1'b0;
        applyStimulus(0, 2'b00, 4'h0, 1, 64'hFFFF_0000_FFFF_0000, 2'b00, 4'hD, 0, 0);
        checkResp("mrst", 0, 0, 4'h0, 32'h0);
        checkOutput("mrst_lane_ready", 64'(lane_ready_o), 64'd1);
        checkOutput("mrst_b_ready", 64'(b_ready_o), 64'd0);
        checkOutput("mrst_r_ready", 64'(r_ready_o), 64'd0);
        step();
        checkOutput("mrst_valid2", 64'(per_r_valid_o), 64'd0);
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);

        // Contention: two lanes queued, B and R held for 4 cycles
        $display("[TB] contention");
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 0);
        step();
        applyStimulus(1, 2'b11, 4'h9, 1, 64'h1111_2222_3333_4444, 2'b00, 4'h6, 0, 0);
        checkOutput("ct1_r_ready", 64'(r_ready_o), 64'd1);
        checkOutput("ct1_b_ready", 64'(b_ready_o), 64'd0);
        step();
        checkResp("ct1", 1, 0, 4'h6, 32'h1111_2222);
        checkOutput("ct2_b_ready", 64'(b_ready_o), 64'd1);
        checkOutput("ct2_r_ready", 64'(r_ready_o), 64'd0);
        step();
        applyStimulus(1, 2'b11, 4'h9, 1, 64'h5555_6666_7777_8888, 2'b00, 4'h6, 0, 0);
        checkResp("ct2", 1, 1, 4'h9, 32'h0);
        checkOutput("ct3_r_ready", 64'(r_ready_o), 64'd1);
        step();
        checkResp("ct3", 1, 0, 4'h6, 32'h7777_8888);
        checkOutput("ct4_b_ready", 64'(b_ready_o), 64'd1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        checkResp("ct4", 1, 1, 4'h9, 32'h0);
        step();
        checkOutput("ct_idle", 64'(per_r_valid_o), 64'd0);

        // Lane FIFO full; a push while full is dropped even with a pop
        $display("[TB] fifo full");
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 0);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 0);
        step();
        checkOutput("full_ready3", 64'(lane_ready_o), 64'd1);
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 1, 1);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        checkOutput("full_ready4", 64'(lane_ready_o), 64'd0);
        applyStimulus(0, 2'b00, 4'h0, 1, 64'hDEAD_BEEF_0123_4567, 2'b00, 4'h3, 1, 1);
        checkOutput("full_r_ready", 64'(r_ready_o), 64'd1);
        checkOutput("full_lane_ready", 64'(lane_ready_o), 64'd0);
        step();
        applyStimulus(0, 2'b00, 4'h0, 1, 64'hDEAD_BEEF_0123_4567, 2'b00, 4'h3, 0, 0);
        checkResp("full_pop1", 1, 0, 4'h3, 32'h0123_4567);
        checkOutput("full_ready_after1", 64'(lane_ready_o), 64'd1);
        step();
        checkResp("full_pop2", 1, 0, 4'h3, 32'hDEAD_BEEF);
        step();
        checkResp("full_pop3", 1, 0, 4'h3, 32'h0123_4567);
        step();
        checkResp("full_pop4", 1, 0, 4'h3, 32'hDEAD_BEEF);
        checkOutput("full_drained_r_ready", 64'(r_ready_o), 64'd0);
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        step();
        checkOutput("full_idle", 64'(per_r_valid_o), 64'd0);

        // Error counter: 3 DECERR then 1 OKAY after a clean reset
        $display("[TB] error count");
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
`ifdef PER2AXI_RESP_ERR_CNT_EN
        exp_err = 16'd3;
`else
        exp_err = 16'd0;
`endif
        applyStimulus(1, 2'b11, 4'h1, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        step();
        applyStimulus(1, 2'b11, 4'h2, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        step();
        applyStimulus(1, 2'b11, 4'h3, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        step();
        applyStimulus(1, 2'b00, 4'h4, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        step();
        applyStimulus(0, 2'b00, 4'h0, 0, 64'h0, 2'b00, 4'h0, 0, 0);
        checkResp("err_last", 1, 0, 4'h4, 32'h0);
        step();
        checkOutput("err_cnt", 64'(err_cnt_o), 64'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
